// File: rtl/fir_mac_scheduler_if.sv
// Coefficient SRAM bus: per-bank select/strobe, shared row address and write data.
interface fir_mac_scheduler_if #(
    parameter int COEFF_W = 16,
    parameter int ROW_W   = 4
);
    logic [3:0]         oCsnRam;
    logic [3:0]         oWrnRam;
    logic [ROW_W-1:0]   oAddrRam;
    logic [COEFF_W-1:0] oWrDtRam;

    modport master (
        output oCsnRam,
        output oWrnRam,
        output oAddrRam,
        output oWrDtRam
    );

    modport slave (
        input oCsnRam,
        input oWrnRam,
        input oAddrRam,
        input oWrDtRam
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Sequencer for the 4-bank FIR MAC datapath (coefficient load, read, MAC/Sum enables).
// Optional FIR_SCHED_STATUS_EN adds oSampleCnt / oOverrunCnt status counters.
module fir_mac_scheduler #(
    parameter int COEFF_W  = 16,
    parameter int ROW_W    = 4,
    parameter int NUM_ROWS = 10
) (
    input  logic               iClk12M,
    input  logic               iRsn,
    input  logic               iEnSample600k,
    input  logic               iCoeffUpdateFlag,
    input  logic [5:0]         iAddrRam,
    input  logic [COEFF_W-1:0] iWrDtRam,
    input  logic [5:0]         iNumOfCoeff,
    fir_mac_scheduler_if.master ram,
    output logic               oEnDelay,
    output logic [3:0]         oZeroCoeff,
    output logic               oEnMul,
    output logic               oEnAdd,
    output logic               oEnAcc,
    output logic               oEnSum,
    output logic               oBusy,
    output logic               oOverrun,
`ifdef FIR_SCHED_STATUS_EN
    output logic               oUpdDrop,
    output logic [15:0]        oSampleCnt,
    output logic [7:0]         oOverrunCnt
`else
    output logic               oUpdDrop
`endif
);

    localparam logic [5:0] MAXC = 6'(4 * NUM_ROWS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UPD   = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_SUM   = 3'd5;

    logic [2:0]         r_state;
    logic [3:0]         r_cyc;
    logic [5:0]         r_nc;
    logic [3:0]         r_rows;
    logic [3:0]         r_csn;
    logic [3:0]         r_wrn;
    logic [ROW_W-1:0]   r_addr;
    logic [COEFF_W-1:0] r_wdt;
    logic               r_del;
    logic [3:0]         r_zero;
    logic               r_mul;
    logic               r_add;
    logic               r_acc;
    logic               r_sum;
    logic               r_busy;
    logic               r_ovr;
    logic               r_udrop;

    logic [2:0]         w_state;
    logic [3:0]         w_cyc;
    logic [5:0]         w_nc;
    logic [3:0]         w_rows;
    logic [3:0]         w_csn;
    logic [3:0]         w_wrn;
    logic [ROW_W-1:0]   w_addr;
    logic [COEFF_W-1:0] w_wdt;
    logic               w_del;
    logic [3:0]         w_zero;
    logic               w_mul;
    logic               w_add;
    logic               w_acc;
    logic               w_sum;
    logic               w_ovr;
    logic               w_udrop;
    logic [4:0]         w_n;
    logic [4:0]         w_r5;
    logic [5:0]         w_lim;
    logic [ROW_W-1:0]   w_rd_row;
    logic [ROW_W-1:0]   w_zr_row;

    // Bit b set when tap 4*row+b lies beyond the active tap count.
    function automatic logic [3:0] f_mask(
        input logic [ROW_W-1:0] row,
        input logic [5:0]       nc
    );
        logic [1:0] bb;
        for (int b = 0; b < 4; b++) begin
            bb = 2'(b);
            f_mask[b] = (6'({row, bb}) >= nc);
        end
    endfunction

    assign w_n      = {1'b0, r_cyc} + 5'd1;
    assign w_r5     = {1'b0, r_rows};
    assign w_lim    = (iNumOfCoeff > MAXC) ? MAXC : iNumOfCoeff;
    assign w_rd_row = ROW_W'(w_n - 5'd1);
    assign w_zr_row = ROW_W'(w_n - 5'd2);

    always_comb begin
        w_state = r_state;
        w_cyc   = r_cyc;
        w_nc    = r_nc;
        w_rows  = r_rows;
        w_csn   = 4'hF;
        w_wrn   = 4'hF;
        w_addr  = '0;
        w_wdt   = '0;
        w_del   = 1'b0;
        w_zero  = 4'h0;
        w_mul   = 1'b0;
        w_add   = 1'b0;
        w_acc   = 1'b0;
        w_sum   = 1'b0;
        w_ovr   = 1'b0;
        w_udrop = 1'b0;
        unique case (r_state)
            S_IDLE, S_UPD: begin
                if (iCoeffUpdateFlag) begin
                    w_state = S_UPD;
                    w_ovr   = iEnSample600k;
                    if (iAddrRam < MAXC) begin
                        w_csn[iAddrRam[1:0]] = 1'b0;
                        w_wrn[iAddrRam[1:0]] = 1'b0;
                        w_addr = ROW_W'(iAddrRam[5:2]);
                        w_wdt  = iWrDtRam;
                    end else begin
                        w_udrop = 1'b1;
                    end
                end else if (iEnSample600k && r_state == S_IDLE) begin
                    w_state = S_SHIFT;
                    w_cyc   = 4'd0;
                    w_nc    = w_lim;
                    w_rows  = 4'((w_lim + 6'd3) >> 2);
                    w_del   = 1'b1;
                end else begin
                    w_state = S_IDLE;
                    w_ovr   = iEnSample600k;
                end
            end
            default: begin
                w_udrop = iCoeffUpdateFlag;
                w_ovr   = iEnSample600k;
                if (r_state == S_SHIFT && r_nc == 6'd0) begin
                    w_state = S_IDLE;
                end else begin
                    // w_n is the cycle offset from the SHIFT cycle being prepared.
                    w_cyc = w_n[3:0];
                    if (w_n <= w_r5) begin
                        w_state = S_READ;
                        w_csn   = f_mask(w_rd_row, r_nc);
                        w_addr  = w_rd_row;
                    end else if (w_n <= w_r5 + 5'd2) begin
                        w_state = S_DRAIN;
                    end else if (w_n == w_r5 + 5'd3) begin
                        w_state = S_SUM;
                        w_sum   = 1'b1;
                    end else begin
                        w_state = S_IDLE;
                    end
                    if (w_n >= 5'd2 && w_n <= w_r5 + 5'd1) begin
                        w_mul  = 1'b1;
                        w_zero = f_mask(w_zr_row, r_nc);
                    end
                    w_add = (w_n == 5'd3);
                    w_acc = (w_n >= 5'd4) && (w_n <= w_r5 + 5'd2);
                end
            end
        endcase
    end

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_state <= S_IDLE;
            r_cyc   <= 4'd0;
            r_nc    <= 6'd0;
            r_rows  <= 4'd0;
            r_csn   <= 4'hF;
            r_wrn   <= 4'hF;
            r_addr  <= '0;
            r_wdt   <= '0;
            r_del   <= 1'b0;
            r_zero  <= 4'h0;
            r_mul   <= 1'b0;
            r_add   <= 1'b0;
            r_acc   <= 1'b0;
            r_sum   <= 1'b0;
            r_busy  <= 1'b0;
            r_ovr   <= 1'b0;
            r_udrop <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cyc   <= w_cyc;
            r_nc    <= w_nc;
            r_rows  <= w_rows;
            r_csn   <= w_csn;
            r_wrn   <= w_wrn;
            r_addr  <= w_addr;
            r_wdt   <= w_wdt;
            r_del   <= w_del;
            r_zero  <= w_zero;
            r_mul   <= w_mul;
            r_add   <= w_add;
            r_acc   <= w_acc;
            r_sum   <= w_sum;
            r_busy  <= (w_state != S_IDLE);
            r_ovr   <= w_ovr;
            r_udrop <= w_udrop;
        end
    end

`ifdef FIR_SCHED_STATUS_EN
    logic [15:0] r_scnt;
    logic [7:0]  r_ocnt;

    always_ff @(posedge iClk12M or negedge iRsn) begin
        if (!iRsn) begin
            r_scnt <= 16'd0;
            r_ocnt <= 8'd0;
        end else begin
            if (w_sum)
                r_scnt <= r_scnt + 16'd1;
            if (w_ovr && r_ocnt != 8'hFF)
                r_ocnt <= r_ocnt + 8'd1;
        end
    end

    assign oSampleCnt  = r_scnt;
    assign oOverrunCnt = r_ocnt;
`endif

    assign ram.oCsnRam  = r_csn;
    assign ram.oWrnRam  = r_wrn;
    assign ram.oAddrRam = r_addr;
    assign ram.oWrDtRam = r_wdt;
    assign oEnDelay     = r_del;
    assign oZeroCoeff   = r_zero;
    assign oEnMul       = r_mul;
    assign oEnAdd       = r_add;
    assign oEnAcc       = r_acc;
    assign oEnSum       = r_sum;
    assign oBusy        = r_busy;
    assign oOverrun     = r_ovr;
    assign oUpdDrop     = r_udrop;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: coefficient load, tap-count sequences,
// overrun/drop pulses and asynchronous reset.
module tb_fir_mac_scheduler;

    logic        clk  = 1'b0;
    logic        rsn  = 1'b0;
    logic        strb = 1'b0;
    logic        flag = 1'b0;
    logic [5:0]  k    = 6'd0;
    logic [15:0] wdt  = 16'd0;
    logic [5:0]  ncoef = 6'd0;

    logic        oEnDelay;
    logic [3:0]  oZeroCoeff;
    logic        oEnMul;
    logic        oEnAdd;
    logic        oEnAcc;
    logic        oEnSum;
    logic        oBusy;
    logic        oOverrun;
    logic        oUpdDrop;
`ifdef FIR_SCHED_STATUS_EN
    logic [15:0] oSampleCnt;
    logic [7:0]  oOverrunCnt;
`endif

    int checks = 0;
    int errors = 0;

    fir_mac_scheduler_if #(.COEFF_W(16), .ROW_W(4)) ram_if ();

    always #5 clk = ~clk;

    fir_mac_scheduler #(
        .COEFF_W (16),
        .ROW_W   (4),
        .NUM_ROWS(10)
    ) dut (
        .iClk12M         (clk),
        .iRsn            (rsn),
        .iEnSample600k   (strb),
        .iCoeffUpdateFlag(flag),
        .iAddrRam        (k),
        .iWrDtRam        (wdt),
        .iNumOfCoeff     (ncoef),
        .ram             (ram_if),
        .oEnDelay        (oEnDelay),
        .oZeroCoeff      (oZeroCoeff),
        .oEnMul          (oEnMul),
        .oEnAdd          (oEnAdd),
        .oEnAcc          (oEnAcc),
        .oEnSum          (oEnSum),
        .oBusy           (oBusy),
        .oOverrun        (oOverrun),
`ifdef FIR_SCHED_STATUS_EN
        .oUpdDrop        (oUpdDrop),
        .oSampleCnt      (oSampleCnt),
        .oOverrunCnt     (oOverrunCnt)
`else
        .oUpdDrop        (oUpdDrop)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] vec();
        return {40'd0, oEnDelay, ram_if.oCsnRam, ram_if.oWrnRam,
                ram_if.oAddrRam, oEnMul, oEnAdd, oEnAcc, oEnSum, oBusy,
                oZeroCoeff, oOverrun, oUpdDrop};
    endfunction

    function automatic logic [63:0] ev(
        input logic del, input logic [3:0] csn, input logic [3:0] wrn,
        input logic [3:0] addr, input logic mul, input logic add,
        input logic acc, input logic sum, input logic busy,
        input logic [3:0] zero, input logic ovr, input logic udrop);
        return {40'd0, del, csn, wrn, addr, mul, add, acc, sum, busy,
                zero, ovr, udrop};
    endfunction

    // Strobe a sample and check every cycle from T (c=0) until back in idle.
    // r = expected row count, last = expected mask of the final row.
    task automatic seq(input logic [5:0] n, input int r,
                       input logic [3:0] last, input int ovr_at);
        int   last_c;
        logic rd;
        logic nz;
        ncoef = n;
        strb  = 1'b1;
        tick();
        strb  = 1'b0;
        last_c = (r == 0) ? 1 : r + 4;
        nz = (r != 0);
        for (int c = 0; c <= last_c; c++) begin
            rd = nz && c >= 1 && c <= r;
            chk($sformatf("seq_n%0d_c%0d", n, c), vec(),
                ev(c == 0,
                   rd ? ((c == r) ? last : 4'h0) : 4'hF,
                   4'hF,
                   rd ? 4'(c - 1) : 4'h0,
                   nz && c >= 2 && c <= r + 1,
                   nz && c == 3,
                   nz && c >= 4 && c <= r + 2,
                   nz && c == r + 3,
                   nz ? (c <= r + 3) : (c == 0),
                   (nz && c == r + 1) ? last : 4'h0,
                   c == ovr_at + 1,
                   1'b0));
            strb = (c == ovr_at);
            tick();
        end
        strb = 1'b0;
    endtask

    initial begin
        logic [3:0] m;
        bit         done;

        tick();
        tick();
        chk("reset", vec(), ev(0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef FIR_SCHED_STATUS_EN
        chk("reset_cnt", {oSampleCnt, oOverrunCnt}, 24'd0);
`endif
        rsn = 1'b1;
        tick();

        // Coefficient load k=0..39, data=k+1
        flag = 1'b1;
        for (int i = 0; i < 40; i++) begin
            k   = 6'(i);
            wdt = 16'(i + 1);
            tick();
            m = ~(4'b0001 << (i % 4));
            chk($sformatf("upd_k%0d", i),
                {ram_if.oCsnRam, ram_if.oWrnRam, ram_if.oAddrRam,
                 ram_if.oWrDtRam, oBusy, oUpdDrop},
                {m, m, 4'(i / 4), 16'(i + 1), 1'b1, 1'b0});
        end
        k = 6'd40;
        tick();
        chk("upd_k40_drop",
            {ram_if.oCsnRam, ram_if.oWrnRam, oUpdDrop, oBusy},
            {4'hF, 4'hF, 1'b1, 1'b1});
        flag = 1'b0;
        tick();
        chk("upd_exit", {oBusy, oUpdDrop, ram_if.oCsnRam}, {1'b0, 1'b0, 4'hF});

        // Flag and strobe together in idle: update wins, strobe dropped
        flag = 1'b1;
        k    = 6'd7;
        wdt  = 16'h00AA;
        strb = 1'b1;
        tick();
        chk("flag_strobe", {oBusy, oOverrun, ram_if.oCsnRam, ram_if.oAddrRam},
            {1'b1, 1'b1, 4'b0111, 4'd1});
        strb = 1'b0;
        flag = 1'b0;
        tick();
        chk("flag_strobe_exit", {oBusy, oOverrun}, 2'b00);

        seq(6'd40, 10, 4'b0000, 99);
        seq(6'd6,  2,  4'b1100, 99);
        seq(6'd1,  1,  4'b1110, 99);
        seq(6'd0,  0,  4'b0000, 99);
        seq(6'd63, 10, 4'b0000, 99);
        seq(6'd40, 10, 4'b0000, 5);

        // Coefficient write attempted while busy
        ncoef = 6'd6;
        strb  = 1'b1;
        tick();
        strb  = 1'b0;
        flag  = 1'b1;
        k     = 6'd3;
        tick();
        chk("upd_busy", {oUpdDrop, oBusy, ram_if.oCsnRam, ram_if.oWrnRam},
            {1'b1, 1'b1, 4'h0, 4'hF});
        flag = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            if (!oBusy) done = 1'b1;
        end
        chk("upd_busy_idle", {31'd0, done}, 32'd1);
`ifdef FIR_SCHED_STATUS_EN
        chk("cnt_sum", {16'd0, oSampleCnt}, 32'd6);
        chk("cnt_ovr", {24'd0, oOverrunCnt}, 32'd2);
`endif

        // Asynchronous reset mid-sequence at T+6
        ncoef = 6'd40;
        strb  = 1'b1;
        tick();
        strb  = 1'b0;
        repeat (6) tick();
        chk("pre_reset_busy", {oBusy, oEnMul}, 2'b11);
        #2;
        rsn = 1'b0;
        #1;
        chk("async_reset", vec(), ev(0, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef FIR_SCHED_STATUS_EN
        chk("async_reset_cnt", {oSampleCnt, oOverrunCnt}, 24'd0);
`endif
        tick();
        rsn = 1'b1;
        tick();
        seq(6'd6, 2, 4'b1100, 99);

`ifdef FIR_SCHED_STATUS_EN
        flag = 1'b1;
        k    = 6'd0;
        strb = 1'b1;
        repeat (260) tick();
        strb = 1'b0;
        flag = 1'b0;
        tick();
        tick();
        chk("cnt_sum_post", {16'd0, oSampleCnt}, 32'd1);
        chk("cnt_ovr_sat", {24'd0, oOverrunCnt}, 32'd255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
